// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end.
//   lb_state_e  : sequencing state of line_buffer_ctrl
//   DEF_WIDTH   : default active pixels per line
//   DEF_HEIGHT  : default active lines per frame
//   cnt_width() : bits needed to hold a count of 0..n
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } lb_state_e;

  localparam int DEF_WIDTH  = 10;
  localparam int DEF_HEIGHT = 5;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_pos_counter.sv
// pos_counter: raster position counter (column wraps at WIDTH, row counts up).
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous reset, active-low
//   clr_i   : return to position 0; with inc_i the counted item becomes
//             position 0, so the counter lands on position 1
//   inc_i   : advance one position
//   col_o   : current column
//   row_o   : current row (not wrapped; may run past LAST_ROW)
//   term_o  : current position is (LAST_ROW, WIDTH-1)
module pos_counter #(
  parameter int WIDTH    = 10,
  parameter int LAST_ROW = 4,
  parameter int CW       = 10,
  parameter int RW       = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          term_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LAST_ROW);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = inc_i ? CW'(1) : '0;
      row_d = '0;
    end else if (inc_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign term_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequencer for the 3x3 line buffer feeding the Sobel kernel.
// Tracks vsync/de, drives the buffer shift/pad controls, appends WIDTH+1 pad
// shifts at end of frame so the last row drains, and tags each valid window
// centre with its position and the image borders it touches.
// Ports:
//   clk, rst (sync, active-low)      : clock / reset
//   vsync, hsync, de                 : input video timing (hsync monitored only)
//   lb_shift, lb_pad                 : combinational line-buffer controls
//   win_valid, win_col, win_row      : registered window-centre qualifier/position
//   bord_top/bot/left/right          : registered border flags of the centre
//   frame_done                       : registered pulse with the last centre
//   err                              : registered one-cycle timing-violation pulse
module line_buffer_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CW     = 10,
  parameter int RW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          hsync,
  input  logic          de,
  output logic          lb_shift,
  output logic          lb_pad,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          bord_top,
  output logic          bord_bot,
  output logic          bord_left,
  output logic          bord_right,
  output logic          frame_done,
  output logic          err
);

  localparam int              RUN_W    = cnt_width(WIDTH) + 1;
  localparam logic [RUN_W-1:0] RUN_LINE = RUN_W'(WIDTH);
  localparam logic [CW-1:0]   COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(HEIGHT - 1);

  lb_state_e        state_q;
  logic [RUN_W-1:0] run_q, run_d;

  logic          win_valid_q, frame_done_q, err_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;
  logic          top_q, bot_q, left_q, right_q;

  logic [CW-1:0] in_col, c_col;
  logic [RW-1:0] in_row, c_row;
  logic          in_term, c_term;

  logic vs_abort, acc_cyc, flush_cyc, cnt_clr, past_lag, produce;
  logic run_bad, err_d;

  logic unused_hsync;
  assign unused_hsync = hsync;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // vsync outside IDLE restarts the frame in the same cycle, so a coincident
  // de pixel is accepted as pixel 0 of the new frame rather than padded.
  assign vs_abort  = vsync && (state_q != ST_IDLE);
  assign acc_cyc   = (state_q == ST_ACTIVE) || vs_abort;
  assign flush_cyc = (state_q == ST_FLUSH) && !vsync;

  assign lb_shift = (acc_cyc && de) || flush_cyc;
  assign lb_pad   = flush_cyc;

  // Counters sit at 0 throughout IDLE so the next frame starts clean.
  assign cnt_clr = vs_abort || (state_q == ST_IDLE);

  // Shifted item index >= WIDTH+1: the window centre is a real pixel.
  assign past_lag = (in_row > RW'(1)) || ((in_row == RW'(1)) && (in_col != '0));
  assign produce  = lb_shift && !vs_abort && past_lag;

  pos_counter #(
    .WIDTH(WIDTH), .LAST_ROW(HEIGHT - 1), .CW(CW), .RW(RW)
  ) u_in_pos (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (cnt_clr),
    .inc_i (lb_shift),
    .col_o (in_col),
    .row_o (in_row),
    .term_o(in_term)
  );

  pos_counter #(
    .WIDTH(WIDTH), .LAST_ROW(HEIGHT - 1), .CW(CW), .RW(RW)
  ) u_ctr_pos (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (cnt_clr),
    .inc_i (produce),
    .col_o (c_col),
    .row_o (c_row),
    .term_o(c_term)
  );

  // Run length of de accepted as frame pixels; de seen in FLUSH or IDLE
  // neither extends nor starts a run.
  always_comb begin
    run_d = run_q;
    if (!de) begin
      run_d = '0;
    end else if (vs_abort) begin
      run_d = RUN_W'(1);
    end else if (acc_cyc) begin
      run_d = sat_inc(run_q);
    end
  end

  assign run_bad = !de && (run_q != '0) && (run_q != RUN_LINE);
  assign err_d   = vs_abort || (flush_cyc && de) || run_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      run_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      top_q        <= 1'b0;
      bot_q        <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
    end else begin
      run_q        <= run_d;
      err_q        <= err_d;
      win_valid_q  <= produce;
      frame_done_q <= produce && c_term;
      if (produce) begin
        win_col_q <= c_col;
        win_row_q <= c_row;
        top_q     <= (c_row == '0);
        bot_q     <= (c_row == ROW_LAST);
        left_q    <= (c_col == '0);
        right_q   <= (c_col == COL_LAST);
      end
      case (state_q)
        ST_IDLE: begin
          if (vsync) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!vsync && de && in_term) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // The last pad shift is the one that produces the final centre.
          if (vsync)       state_q <= ST_ACTIVE;
          else if (c_term) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign bord_top   = top_q;
  assign bord_bot   = bot_q;
  assign bord_left  = left_q;
  assign bord_right = right_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
module tb_line_buffer_ctrl;
  localparam int W  = 10;
  localparam int H  = 5;
  localparam int CW = 10;
  localparam int RW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync = 1'b0;
  logic hsync = 1'b0;
  logic de = 1'b0;
  logic lb_shift, lb_pad, win_valid, frame_done, err;
  logic bord_top, bord_bot, bord_left, bord_right;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;

  line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .hsync(hsync), .de(de),
    .lb_shift(lb_shift), .lb_pad(lb_pad), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row),
    .bord_top(bord_top), .bord_bot(bord_bot), .bord_left(bord_left),
    .bord_right(bord_right), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int n_wv, n_fd, n_pad, n_err, n_shift, n_top, n_bot, n_left, n_right;
  int first_shifts, first_prev, first_row, first_col, first_top, first_left;
  int fd_row, fd_col, fd_bot, fd_right, fd_wv;
  int err_first, err_last;
  int prev_shift;
  int mark;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_wv = 0; n_fd = 0; n_pad = 0; n_err = 0; n_shift = 0;
    n_top = 0; n_bot = 0; n_left = 0; n_right = 0;
    first_shifts = -1; first_prev = -1; first_row = -1; first_col = -1;
    first_top = -1; first_left = -1;
    fd_row = -1; fd_col = -1; fd_bot = -1; fd_right = -1; fd_wv = -1;
    err_first = -1; err_last = -1;
    prev_shift = 0;
  endtask

  // One clock cycle: drive inputs, observe at the falling edge, then advance.
  task automatic step(input logic vs, input logic d);
    vsync = vs;
    de    = d;
    @(negedge clk);
    if (win_valid) begin
      if (n_wv == 0) begin
        first_shifts = n_shift;
        first_prev   = prev_shift;
        first_row    = int'(win_row);
        first_col    = int'(win_col);
        first_top    = int'(bord_top);
        first_left   = int'(bord_left);
      end
      n_wv++;
      if (bord_top)   n_top++;
      if (bord_bot)   n_bot++;
      if (bord_left)  n_left++;
      if (bord_right) n_right++;
    end
    if (frame_done) begin
      n_fd++;
      fd_row   = int'(win_row);
      fd_col   = int'(win_col);
      fd_bot   = int'(bord_bot);
      fd_right = int'(bord_right);
      fd_wv    = int'(win_valid);
    end
    if (err) begin
      n_err++;
      if (err_first < 0) err_first = cyc;
      err_last = cyc;
    end
    if (lb_pad) n_pad++;
    prev_shift = int'(lb_shift);
    if (lb_shift) n_shift++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_line(input int npix, input int gap);
    for (int i = 0; i < npix; i++) step(1'b0, 1'b1);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_stats();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Reset state
    rst   = 1'b1;
    vsync = 1'b0;
    de    = 1'b1;
    @(negedge clk);
    check_eq("rst_shift", 32'(lb_shift), 0);
    check_eq("rst_pad", 32'(lb_pad), 0);
    check_eq("rst_wv", 32'(win_valid), 0);
    check_eq("rst_pos", 32'({win_row, win_col}), 0);
    check_eq("rst_flags", 32'({bord_top, bord_bot, bord_left, bord_right, frame_done, err}), 0);
    @(posedge clk);
    #1;
    cyc++;

    // de while IDLE is ignored
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_eq("idle_de_shift", n_shift, 0);
    check_eq("idle_de_err", n_err, 0);

    // Good frame
    clear_stats();
    step(1'b1, 1'b0);
    for (int l = 0; l < H; l++) send_line(W, 2);
    idle(20);
    check_eq("good_wv", n_wv, 50);
    check_eq("good_pad", n_pad, 11);
    check_eq("good_shift", n_shift, 61);
    check_eq("good_first_after", first_shifts, 12);
    check_eq("good_first_prev_shift", first_prev, 1);
    check_eq("good_first_row", first_row, 0);
    check_eq("good_first_col", first_col, 0);
    check_eq("good_first_top", first_top, 1);
    check_eq("good_first_left", first_left, 1);
    check_eq("good_fd", n_fd, 1);
    check_eq("good_fd_wv", fd_wv, 1);
    check_eq("good_fd_row", fd_row, 4);
    check_eq("good_fd_col", fd_col, 9);
    check_eq("good_fd_bot", fd_bot, 1);
    check_eq("good_fd_right", fd_right, 1);
    check_eq("good_err", n_err, 0);
    check_eq("good_top", n_top, 10);
    check_eq("good_bot", n_bot, 10);
    check_eq("good_left", n_left, 5);
    check_eq("good_right", n_right, 5);

    // Short line (line 2 carries 9 pixels)
    clear_stats();
    step(1'b1, 1'b0);
    send_line(W, 2);
    send_line(W, 2);
    send_line(W - 1, 0);
    mark = cyc;
    idle(2);
    send_line(W, 2);
    send_line(W, 2);
    idle(5);
    check_eq("short_err_cnt", n_err, 1);
    check_eq("short_err_at", err_first, mark + 1);
    check_eq("short_pad", n_pad, 0);
    check_eq("short_fd", n_fd, 0);
    check_eq("short_wv", n_wv, 38);
    mark = cyc;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("short_vs_err_cnt", n_err, 2);
    check_eq("short_vs_err_at", err_last, mark + 1);
    clear_stats();
    for (int l = 0; l < H; l++) send_line(W, 2);
    idle(20);
    check_eq("resync_wv", n_wv, 50);
    check_eq("resync_fd", n_fd, 1);
    check_eq("resync_err", n_err, 0);

    // vsync after 23 pixels
    clear_stats();
    step(1'b1, 1'b0);
    send_line(W, 2);
    send_line(W, 2);
    send_line(3, 0);
    mark = cyc;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("mid_err_cnt", n_err, 1);
    check_eq("mid_err_at", err_first, mark + 1);
    check_eq("mid_fd", n_fd, 0);
    check_eq("mid_wv", n_wv, 12);
    clear_stats();
    for (int l = 0; l < H; l++) send_line(W, 2);
    idle(20);
    check_eq("mid_clean_wv", n_wv, 50);
    check_eq("mid_clean_fd", n_fd, 1);
    check_eq("mid_clean_err", n_err, 0);

    // Reset on the 3rd flush cycle
    clear_stats();
    step(1'b1, 1'b0);
    for (int l = 0; l < H - 1; l++) send_line(W, 2);
    send_line(W, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    check_eq("rstf_pad_before", n_pad, 3);
    check_eq("rstf_fd", n_fd, 0);
    rst   = 1'b1;
    vsync = 1'b0;
    de    = 1'b1;
    @(negedge clk);
    check_eq("rstf_shift", 32'(lb_shift), 0);
    check_eq("rstf_pad", 32'(lb_pad), 0);
    check_eq("rstf_wv", 32'(win_valid), 0);
    @(posedge clk);
    #1;
    cyc++;
    clear_stats();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check_eq("rstf_idle_shift", n_shift, 0);
    check_eq("rstf_idle_wv", n_wv, 0);
    check_eq("rstf_idle_err", n_err, 0);

    // de on flush cycle 5
    clear_stats();
    step(1'b1, 1'b0);
    for (int l = 0; l < H - 1; l++) send_line(W, 2);
    send_line(W, 0);
    idle(4);
    mark = cyc;
    step(1'b0, 1'b1);
    idle(20);
    check_eq("fde_pad", n_pad, 11);
    check_eq("fde_err_cnt", n_err, 1);
    check_eq("fde_err_at", err_first, mark + 1);
    check_eq("fde_fd", n_fd, 1);
    check_eq("fde_wv", n_wv, 50);
    check_eq("fde_shift", n_shift, 61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
